// File: rtl/bcd_dabble_ctrl.sv
// bcd_dabble_ctrl: sequential binary-to-BCD converter (shift-add-3 / double dabble), one bit per clock.
// Latency: start accepted at edge t, busy for WIDTH cycles, done pulses for the single cycle after edge t+WIDTH.
// Backpressure: none. start is only sampled while idle, and a start that arrives while busy is dropped, not queued.
//
// Ports:
//   clk, rst_n   single clock, asynchronous active-low reset
//   start        conversion request, sampled while busy=0 (the done cycle included)
//   bin_in       binary operand [WIDTH-1:0], captured on the edge that accepts start
//   busy         high while a conversion is in progress
//   done         one-cycle pulse when bcd_out is updated
//   bcd_out      packed BCD result [4*DIGITS-1:0], ones digit in [3:0], held until the next done
//   ovf          only when BCD_OVF_EN is defined: a 1 was shifted out of the top BCD digit
//
// Build option: define BCD_OVF_EN to add the ovf output and its sticky overflow tracking.
// Without it, results that need more than DIGITS digits are silently truncated to the low digits.
// Parameter limits: WIDTH 4..16 and 4*DIGITS >= WIDTH.

module bcd_dabble_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
`ifdef BCD_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int BW = 4 * DIGITS;       // BCD field width
  localparam int SW = BW + WIDTH;       // shift register: {BCD field, binary field}
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   shreg;
  logic [SW-1:0]   corr;
  logic [SW-1:0]   shifted;
  logic [CW-1:0]   cnt;
  logic            load;
  logic            step;
  logic            last;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        step = 1'b1;
        // The edge that takes cnt from 1 to 0 is the last shift. It also publishes the result.
        if (cnt == CW'(1)) begin
          last      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state == S_SHIFT);

  // ---------------------------------------------------------------------------
  // Per-digit add-3 correction, then a one-bit left shift. Each BCD digit is
  // corrected on its own (4-bit add, no carry between digits). Correcting
  // before the shift keeps each digit below 10 after it is doubled.
  // ---------------------------------------------------------------------------
  always_comb begin
    corr = shreg;
    for (int i = 0; i < DIGITS; i++) begin
      if (shreg[WIDTH + 4*i +: 4] >= 4'd5) begin
        corr[WIDTH + 4*i +: 4] = shreg[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
    shifted = corr << 1;
  end

  // ---------------------------------------------------------------------------
  // Datapath: shift register, bit counter, result register, done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      cnt     <= '0;
      bcd_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= last;
      if (load) begin
        shreg <= {{BW{1'b0}}, bin_in};
        cnt   <= CW'(WIDTH);
      end else if (step) begin
        shreg <= shifted;
        cnt   <= cnt - CW'(1);
      end
      // bcd_out only ever changes here, so downstream logic never sees a partial result.
      if (last) begin
        bcd_out <= shifted[SW-1 -: BW];
      end
    end
  end

`ifdef BCD_OVF_EN
  // ---------------------------------------------------------------------------
  // Overflow: corr[SW-1] is the bit that the current shift pushes out of the
  // top BCD digit. The flag is sticky across one conversion. The last shift's
  // carry-out is folded in directly when ovf is registered.
  // ---------------------------------------------------------------------------
  logic ovf_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_flag <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (load) begin
        ovf_flag <= 1'b0;
      end else if (step) begin
        ovf_flag <= ovf_flag | corr[SW-1];
      end
      if (last) begin
        ovf <= ovf_flag | corr[SW-1];
      end
    end
  end
`endif

endmodule

// File: tb/tb_bcd_dabble_ctrl.sv
// Directed test bench for bcd_dabble_ctrl (WIDTH=8, DIGITS=3).
// Expected BCD values are hand-computed decimal renderings of the operands.
// With BCD_OVF_EN defined, a second two-digit instance checks the overflow flag.

module tb_bcd_dabble_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin_in;
  logic        busy;
  logic        done;
  logic [11:0] bcd_out;
`ifdef BCD_OVF_EN
  logic        ovf;
  logic        busy2;
  logic        done2;
  logic [7:0]  bcd2;
  logic        ovf2;
`endif

  int vectors = 0;
  int errors  = 0;

  bcd_dabble_ctrl #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
`ifdef BCD_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

`ifdef BCD_OVF_EN
  bcd_dabble_ctrl #(.WIDTH(8), .DIGITS(2)) u_dut2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy2),
    .done    (done2),
    .bcd_out (bcd2),
    .ovf     (ovf2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The caller must be at a negedge. This issues a one-cycle start, pulses
  // start once more while busy (which must be ignored), then returns at the
  // negedge of the done cycle.
  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp, input string name);
    int  nb;
    int  k;
    bit  seen;
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'hA5;
    nb   = 0;
    k    = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) nb++;
        if (k == 3) start = 1'b1;
        if (k == 4) start = 1'b0;
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: done seen=%0d required=1", name, seen);
    end
    vectors++;
    if (nb !== 8) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d required 8", name, nb);
    end
    vectors++;
    if (bcd_out !== exp) begin
      errors++;
      $display("FAIL %s_bcd: got %h required %h", name, bcd_out, exp);
    end
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = 8'd0;
    #12;
    vectors++;
    if ({busy, done, bcd_out} !== 14'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b bcd=%h required 0 0 000", busy, done, bcd_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0]  vin [4]  = '{8'd255, 8'd0, 8'd99, 8'd10};
    logic [11:0] vexp [4] = '{12'h255, 12'h000, 12'h099, 12'h010};
    for (int i = 0; i < 4; i++) begin
      run_conv(vin[i], vexp[i], $sformatf("basic%0d", i));
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || bcd_out !== vexp[i]) begin
        errors++;
        $display("FAIL basic%0d_hold: done=%b bcd=%h required 0 %h", i, done, bcd_out, vexp[i]);
      end
    end
  endtask

  // start held high. bin_in is corrupted while busy, so only the value
  // present at acceptance can matter.
  task automatic test_hold_start;
    int run;
    int dn;
    run = 0;
    dn  = 0;
    start  = 1'b1;
    bin_in = 8'd128;
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      if (busy) begin
        run++;
        bin_in = 8'd0;
      end else begin
        bin_in = 8'd128;
      end
      if (done) begin
        dn++;
        vectors++;
        if (bcd_out !== 12'h128 || run !== 8) begin
          errors++;
          $display("FAIL hold_done%0d: bcd=%h busy_run=%0d required 128 8", dn, bcd_out, run);
        end
        run = 0;
      end
    end
    start = 1'b0;
    vectors++;
    if (dn !== 3) begin
      errors++;
      $display("FAIL hold_done_count: got %0d required 3", dn);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle_after: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int spurious;
    start  = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, bcd_out} !== 14'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b bcd=%h required 0 0 000", busy, done, bcd_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    vectors++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: active cycles=%0d required 0", spurious);
    end
    run_conv(8'd42, 12'h042, "after_reset");
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    run_conv(8'd255, 12'h255, "b2b_first");
    // Still in the done cycle, so this start must be accepted immediately.
    run_conv(8'd7, 12'h007, "b2b_second");
    @(negedge clk);
  endtask

`ifdef BCD_OVF_EN
  task automatic test_ovf;
    logic [7:0] vin [2]  = '{8'd255, 8'd99};
    logic [7:0] vexp [2] = '{8'h55, 8'h99};
    logic       vovf [2] = '{1'b1, 1'b0};
    int k;
    for (int i = 0; i < 2; i++) begin
      start  = 1'b1;
      bin_in = vin[i];
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done2 && k < 40) begin
        @(negedge clk);
        k++;
      end
      vectors++;
      if (done2 !== 1'b1 || ovf2 !== vovf[i] || bcd2 !== vexp[i]) begin
        errors++;
        $display("FAIL ovf%0d: done=%b ovf=%b bcd=%h required 1 %b %h", i, done2, ovf2, bcd2, vovf[i], vexp[i]);
      end
      vectors++;
      if (ovf !== 1'b0) begin
        errors++;
        $display("FAIL ovf%0d_wide: ovf=%b required 0", i, ovf);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_hold_start();
    test_reset_mid();
    test_back_to_back();
`ifdef BCD_OVF_EN
    test_ovf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
